noc_port_arbiter: RTL and testbench

Round-robin output-port arbiter for one ring router port. Three first-word-fall-through input FIFOs (East, West, Local) contend for one outbound link. The arbiter grants one owner at a time, keeps it for a bounded burst, pops flits from the owner's FIFO and drives a registered write/data pair toward the neighbour router. It honours the neighbour's full/almost_full backpressure. One instance sits in front of each router output (E, W, L) in the 4-node ring.

---
 rtl/noc_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_noc_port_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_port_arbiter.sv
// Round-robin output-port arbiter for one ring router port.
// Three FWFT input FIFOs (E, W, L) share one outbound link; the owner keeps the link
// for at most BURST flits, and the flit/strobe toward the neighbour are registered.
module noc_port_arbiter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BURST = 4,
  parameter int unsigned CNTW  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       req,
  input  logic [WIDTH-1:0] data_in_e,
  input  logic [WIDTH-1:0] data_in_w,
  input  logic [WIDTH-1:0] data_in_l,
  input  logic             dst_full,
  input  logic             dst_almost_full,
  output logic [2:0]       pop,
  output logic [2:0]       grant,
  output logic             write_out,
  output logic [WIDTH-1:0] data_out
);

  typedef enum logic {StIdle, StBusy} state_e;

  localparam logic [CNTW-1:0] BurstLast = CNTW'(BURST - 1);

  state_e           state_q, state_d;
  logic [2:0]       grant_q, grant_d;
  logic [1:0]       last_q, last_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             write_out_q, write_out_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;

  logic [1:0] win_idx;
  logic [2:0] win_onehot;
  logic       owner_req;
  logic       allow;
  logic       burst_end;
  logic       release_owner;

  // A write already in flight fills the last free slot, so almost_full must also stall.
  assign allow     = !dst_full && !(dst_almost_full && write_out_q);
  assign owner_req = |(req & grant_q);

  // Round-robin winner: first requester strictly after last_q; last_q only if sole.
  always_comb begin
    win_idx = 2'd0;
    case (last_q)
      2'd0: begin
        if (req[1])      win_idx = 2'd1;
        else if (req[2]) win_idx = 2'd2;
        else             win_idx = 2'd0;
      end
      2'd1: begin
        if (req[2])      win_idx = 2'd2;
        else if (req[0]) win_idx = 2'd0;
        else             win_idx = 2'd1;
      end
      default: begin
        if (req[0])      win_idx = 2'd0;
        else if (req[1]) win_idx = 2'd1;
        else             win_idx = 2'd2;
      end
    endcase
  end

  assign win_onehot = 3'b001 << win_idx;

  // Read strobe to the owner FIFO; never issued in the IDLE cycle.
  always_comb begin
    pop = 3'b000;
    if (state_q == StBusy && owner_req && allow) begin
      pop = grant_q;
    end
  end

  assign burst_end     = (|pop) && (cnt_q == BurstLast);
  assign release_owner = (state_q == StBusy) && (burst_end || !owner_req);

  // Next-state for grant/ownership FSM and the registered output stage.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    write_out_d = |pop;
    data_out_d  = data_out_q;

    unique case (state_q)
      StIdle: begin
        if (|req) begin
          grant_d = win_onehot;
          last_d  = win_idx;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (release_owner) begin
          // Hand over on the same edge when anyone is still asking.
          if (|req) begin
            grant_d = win_onehot;
            last_d  = win_idx;
            cnt_d   = '0;
          end else begin
            grant_d = 3'b000;
            cnt_d   = '0;
            state_d = StIdle;
          end
        end else if (|pop) begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    unique case (pop)
      3'b001:  data_out_d = data_in_e;
      3'b010:  data_out_d = data_in_w;
      3'b100:  data_out_d = data_in_l;
      default: data_out_d = data_out_q;
    endcase
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      grant_q     <= 3'b000;
      last_q      <= 2'd2;
      cnt_q       <= '0;
      write_out_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      write_out_q <= write_out_d;
      data_out_q  <= data_out_d;
    end
  end

  assign grant     = grant_q;
  assign write_out = write_out_q;
  assign data_out  = data_out_q;

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Directed bench for noc_port_arbiter with FWFT FIFO models on the three inputs.
module tb_noc_port_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  req;
  logic [15:0] data_in_e, data_in_w, data_in_l;
  logic        dst_full, dst_almost_full;
  logic [2:0]  pop, grant;
  logic        write_out;
  logic [15:0] data_out;

  logic [15:0] q_e[$];
  logic [15:0] q_w[$];
  logic [15:0] q_l[$];
  logic [2:0]  pop_s;
  logic [15:0] tmp;
  int          n_tests;
  int          n_fail;

  noc_port_arbiter #(.WIDTH(16), .BURST(4), .CNTW(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .req             (req),
    .data_in_e       (data_in_e),
    .data_in_w       (data_in_w),
    .data_in_l       (data_in_l),
    .dst_full        (dst_full),
    .dst_almost_full (dst_almost_full),
    .pop             (pop),
    .grant           (grant),
    .write_out       (write_out),
    .data_out        (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void refresh();
    req       = {q_l.size() > 0, q_w.size() > 0, q_e.size() > 0};
    data_in_e = (q_e.size() > 0) ? q_e[0] : 16'h0;
    data_in_w = (q_w.size() > 0) ? q_w[0] : 16'h0;
    data_in_l = (q_l.size() > 0) ? q_l[0] : 16'h0;
  endfunction

  // One clock: sample pop before the edge, retire popped heads just after it,
  // return on the following negedge.
  task automatic cyc();
    #1;
    pop_s = pop;
    @(posedge clk);
    #1;
    if (pop_s[0] && q_e.size() > 0) tmp = q_e.pop_front();
    if (pop_s[1] && q_w.size() > 0) tmp = q_w.pop_front();
    if (pop_s[2] && q_l.size() > 0) tmp = q_l.pop_front();
    refresh();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    dst_full = 1'b0;
    dst_almost_full = 1'b0;
    q_e.delete();
    q_w.delete();
    q_l.delete();
    refresh();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b0;
    #1;
    n_tests++;
    if (grant !== 3'b000) begin $display("FAIL rst_grant: got %b want 000", grant); n_fail++; end
    n_tests++;
    if (write_out !== 1'b0) begin $display("FAIL rst_wr: got %b want 0", write_out); n_fail++; end
    n_tests++;
    if (data_out !== 16'h0) begin $display("FAIL rst_data: got %h want 0000", data_out); n_fail++; end
    n_tests++;
    if (pop !== 3'b000) begin $display("FAIL rst_pop: got %b want 000", pop); n_fail++; end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    for (int i = 0; i < 6; i++) q_e.push_back(16'h11 + 16'(i));
    refresh();
    #1;
    n_tests++;
    if (pop !== 3'b000) begin $display("FAIL single_idle_pop: got %b want 000", pop); n_fail++; end
    cyc();
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (grant !== 3'b001) begin
        $display("FAIL single_grant[%0d]: got %b want 001", i, grant); n_fail++;
      end
      n_tests++;
      if (pop !== 3'b001) begin $display("FAIL single_pop[%0d]: got %b want 001", i, pop); n_fail++; end
      cyc();
      n_tests++;
      if (write_out !== 1'b1 || data_out !== 16'h11 + 16'(i)) begin
        $display("FAIL single_out[%0d]: got wr=%b data=%h want wr=1 data=%h", i, write_out,
                 data_out, 16'h11 + 16'(i));
        n_fail++;
      end
    end
    n_tests++;
    if (pop !== 3'b000) begin $display("FAIL single_drain_pop: got %b want 000", pop); n_fail++; end
    cyc();
    n_tests++;
    if (grant !== 3'b000 || write_out !== 1'b0 || data_out !== 16'h16) begin
      $display("FAIL single_idle: got g=%b wr=%b data=%h want g=000 wr=0 data=0016", grant,
               write_out, data_out);
      n_fail++;
    end
  endtask

  task automatic test_contention();
    logic [15:0] base[3];
    base = '{16'hE0, 16'hA0, 16'hC0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      q_e.push_back(16'hE0 + 16'(i));
      q_w.push_back(16'hA0 + 16'(i));
      q_l.push_back(16'hC0 + 16'(i));
    end
    refresh();
    cyc();
    for (int g = 0; g < 3; g++) begin
      for (int k = 0; k < 4; k++) begin
        n_tests++;
        if (grant !== (3'b001 << g)) begin
          $display("FAIL rr_grant[%0d,%0d]: got %b want %b", g, k, grant, 3'b001 << g);
          n_fail++;
        end
        cyc();
        n_tests++;
        if (write_out !== 1'b1 || data_out !== base[g] + 16'(k)) begin
          $display("FAIL rr_out[%0d,%0d]: got wr=%b data=%h want wr=1 data=%h", g, k,
                   write_out, data_out, base[g] + 16'(k));
          n_fail++;
        end
      end
    end
    n_tests++;
    if (grant !== 3'b001) begin $display("FAIL rr_wrap: got %b want 001", grant); n_fail++; end
    cyc();
    n_tests++;
    if (write_out !== 1'b1 || data_out !== 16'hE4) begin
      $display("FAIL rr_wrap_out: got wr=%b data=%h want wr=1 data=00e4", write_out, data_out);
      n_fail++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 5; i++) q_e.push_back(16'h31 + 16'(i));
    q_w.push_back(16'h41);
    refresh();
    cyc();
    cyc();
    cyc();
    dst_full = 1'b1;
    #1;
    n_tests++;
    if (pop !== 3'b000 || write_out !== 1'b1 || data_out !== 16'h32) begin
      $display("FAIL bp_start: got pop=%b wr=%b data=%h want pop=000 wr=1 data=0032", pop,
               write_out, data_out);
      n_fail++;
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_tests++;
      if (write_out !== 1'b0 || grant !== 3'b001) begin
        $display("FAIL bp_stall[%0d]: got wr=%b g=%b want wr=0 g=001", i, write_out, grant);
        n_fail++;
      end
      if (i < 2) begin
        n_tests++;
        if (pop !== 3'b000) begin $display("FAIL bp_pop[%0d]: got %b want 000", i, pop); n_fail++; end
      end
    end
    dst_full = 1'b0;
    #1;
    n_tests++;
    if (pop !== 3'b001) begin $display("FAIL bp_resume: got %b want 001", pop); n_fail++; end
    cyc();
    n_tests++;
    if (write_out !== 1'b1 || data_out !== 16'h33) begin
      $display("FAIL bp_f3: got wr=%b data=%h want wr=1 data=0033", write_out, data_out); n_fail++;
    end
    cyc();
    n_tests++;
    if (data_out !== 16'h34 || grant !== 3'b010 || pop !== 3'b010) begin
      $display("FAIL bp_f4_switch: got data=%h g=%b pop=%b want data=0034 g=010 pop=010",
               data_out, grant, pop);
      n_fail++;
    end
    cyc();
    n_tests++;
    if (write_out !== 1'b1 || data_out !== 16'h41) begin
      $display("FAIL bp_w: got wr=%b data=%h want wr=1 data=0041", write_out, data_out); n_fail++;
    end
  endtask

  task automatic test_almost_full();
    do_reset();
    for (int i = 0; i < 4; i++) q_e.push_back(16'h51 + 16'(i));
    dst_almost_full = 1'b1;
    refresh();
    cyc();
    for (int i = 0; i < 7; i++) begin
      n_tests++;
      if (pop !== ((i % 2 == 0) ? 3'b001 : 3'b000)) begin
        $display("FAIL af_pop[%0d]: got %b want %b", i, pop, (i % 2 == 0) ? 3'b001 : 3'b000);
        n_fail++;
      end
      cyc();
      n_tests++;
      if (write_out !== (i % 2 == 0)) begin
        $display("FAIL af_wr[%0d]: got %b want %b", i, write_out, i % 2 == 0); n_fail++;
      end
      if (i % 2 == 0) begin
        n_tests++;
        if (data_out !== 16'h51 + 16'(i / 2)) begin
          $display("FAIL af_data[%0d]: got %h want %h", i, data_out, 16'h51 + 16'(i / 2));
          n_fail++;
        end
      end
    end
    do_reset();
    q_e.push_back(16'h5A);
    q_e.push_back(16'h5B);
    dst_full = 1'b1;
    refresh();
    cyc();
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (pop !== 3'b000) begin $display("FAIL full_pop[%0d]: got %b want 000", i, pop); n_fail++; end
      cyc();
      n_tests++;
      if (write_out !== 1'b0) begin
        $display("FAIL full_wr[%0d]: got %b want 0", i, write_out); n_fail++;
      end
    end
    dst_full = 1'b0;
  endtask

  task automatic test_drain();
    do_reset();
    q_w.push_back(16'h61);
    q_w.push_back(16'h62);
    q_l.push_back(16'h71);
    q_l.push_back(16'h72);
    refresh();
    cyc();
    n_tests++;
    if (grant !== 3'b010) begin $display("FAIL drain_first: got %b want 010", grant); n_fail++; end
    cyc();
    cyc();
    n_tests++;
    if (grant !== 3'b010 || pop !== 3'b000 || write_out !== 1'b1 || data_out !== 16'h62) begin
      $display("FAIL drain_last_w: got g=%b pop=%b wr=%b data=%h want g=010 pop=000 wr=1 data=0062",
               grant, pop, write_out, data_out);
      n_fail++;
    end
    cyc();
    n_tests++;
    if (grant !== 3'b100 || pop !== 3'b100) begin
      $display("FAIL drain_switch: got g=%b pop=%b want g=100 pop=100", grant, pop); n_fail++;
    end
    cyc();
    n_tests++;
    if (write_out !== 1'b1 || data_out !== 16'h71) begin
      $display("FAIL drain_l: got wr=%b data=%h want wr=1 data=0071", write_out, data_out);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) q_e.push_back(16'h81 + 16'(i));
    refresh();
    cyc();
    cyc();
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if (grant !== 3'b000 || write_out !== 1'b0 || data_out !== 16'h0 || pop !== 3'b000) begin
      $display("FAIL midrst: got g=%b wr=%b data=%h pop=%b want all zero", grant, write_out,
               data_out, pop);
      n_fail++;
    end
    @(negedge clk);
    q_e.delete();
    q_w.push_back(16'h91);
    refresh();
    @(negedge clk);
    reset = 1'b1;
    cyc();
    n_tests++;
    if (grant !== 3'b010) begin $display("FAIL midrst_grant: got %b want 010", grant); n_fail++; end
    cyc();
    n_tests++;
    if (write_out !== 1'b1 || data_out !== 16'h91) begin
      $display("FAIL midrst_out: got wr=%b data=%h want wr=1 data=0091", write_out, data_out);
      n_fail++;
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    reset = 1'b0;
    dst_full = 1'b0;
    dst_almost_full = 1'b0;
    pop_s = 3'b000;
    tmp = 16'h0;
    refresh();
    @(negedge clk);
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_almost_full();
    test_drain();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
